ysyx_20020207_axi4_burst_sram: RTL and testbench

//  AXI4 slave memory directly downstream of the core's io_master port. It serves
//  IFU burst refills and LSU single-beat loads and stores from an on-chip word

---
 rtl/ysyx_20020207_axi4_burst_sram.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ysyx_20020207_axi4_burst_sram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_20020207_axi4_burst_sram.sv
// AXI4 slave burst SRAM: independent read/write FSMs over a dual-port word array.
// Optional build macro SRAM_RAND_DELAY_EN adds LFSR-driven read latency and AW stalls.
module ysyx_20020207_axi4_burst_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    IDX_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    awready,
  input  logic                    awvalid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awid,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  output logic                    wready,
  input  logic                    wvalid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic [3:0]              bid,
  output logic                    arready,
  input  logic                    arvalid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arid,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              rresp,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast,
  output logic [3:0]              rid
);

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Burst-wide protocol errors: reserved burst type, oversize beats, bad wrap length
  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd2) || (burst == 2'b10 && !wrap_ok(len));
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (off >> (IDX_WIDTH + 2)) == '0;
  endfunction

  // Next beat address; an illegal wrap length degrades to INCR stepping
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return wrap_ok(len) ? ((a & ~mask) | ((a + step) & mask)) : (a + step);
      default: return a + step;
    endcase
  endfunction

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [2:0] r_dly;
  logic [1:0] aw_hold;
  // Free-running 8-bit LFSR, taps 8,6,5,4
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] raddr, ld_addr;
  logic [7:0]            rlen, rcnt;
  logic [2:0]            rsize;
  logic [1:0]            rburst;
  logic                  rerr, ld, ld_last, ld_err;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);

  // Read next-state plus the "load next beat into the R output registers" strobe
  always_comb begin
    r_next  = r_state;
    ld      = 1'b0;
    ld_addr = raddr;
    ld_last = 1'b0;
    ld_err  = rerr;
    case (r_state)
      R_IDLE: if (arvalid) begin
        ld_addr = araddr;
        ld_last = (arlen == 8'd0);
        ld_err  = burst_err(arlen, arsize, arburst);
`ifdef SRAM_RAND_DELAY_EN
        if (lfsr[2:0] != 3'd0) r_next = R_WAIT;
        else begin r_next = R_DATA; ld = 1'b1; end
`else
        r_next = R_DATA;
        ld     = 1'b1;
`endif
      end
      R_WAIT: begin
`ifdef SRAM_RAND_DELAY_EN
        if (r_dly == 3'd1) begin
          r_next  = R_DATA;
          ld      = 1'b1;
          ld_last = (rcnt == 8'd0);
        end
`else
        r_next  = R_DATA;
        ld      = 1'b1;
        ld_last = (rcnt == 8'd0);
`endif
      end
      R_DATA: if (rready) begin
        if (rcnt == 8'd0) r_next = R_IDLE;
        else begin
          ld      = 1'b1;
          ld_addr = next_addr(raddr, rlen, rsize, rburst);
          ld_last = (rcnt == 8'd1);
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, burst context and registered R outputs (array read is read-first)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      rid     <= '0;
`ifdef SRAM_RAND_DELAY_EN
      r_dly   <= '0;
`endif
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && arvalid) begin
        raddr  <= araddr;
        rlen   <= arlen;
        rsize  <= arsize;
        rburst <= arburst;
        rcnt   <= arlen;
        rid    <= arid;
        rerr   <= burst_err(arlen, arsize, arburst);
`ifdef SRAM_RAND_DELAY_EN
        r_dly  <= lfsr[2:0];
`endif
      end else if (ld) begin
        raddr <= ld_addr;
      end
`ifdef SRAM_RAND_DELAY_EN
      if (r_state == R_WAIT) r_dly <= r_dly - 3'd1;
`endif
      if (r_state == R_DATA && rready) begin
        if (rcnt != 8'd0) rcnt <= rcnt - 8'd1;
        else              rlast <= 1'b0;
      end
      if (ld) begin
        rdata <= in_range(ld_addr) ? mem[ld_addr[IDX_WIDTH+1:2]] : '0;
        rresp <= !in_range(ld_addr) ? DECERR : (ld_err ? SLVERR : OKAY);
        rlast <= ld_last;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [7:0]            wlen, wcnt;
  logic [2:0]            wsize;
  logic [1:0]            wburst;
  logic                  werr_slv, werr_dec, aw_ok, w_hs, beat_dec, beat_slv;

`ifdef SRAM_RAND_DELAY_EN
  assign aw_ok = (w_state == W_IDLE) && (aw_hold == 2'd0);
`else
  assign aw_ok = (w_state == W_IDLE);
`endif
  assign awready  = aw_ok;
  assign wready   = (w_state == W_DATA);
  assign bvalid   = (w_state == W_RESP);
  assign w_hs     = (w_state == W_DATA) && wvalid;
  assign beat_dec = !in_range(waddr);
  assign beat_slv = wlast != (wcnt == 8'd0);

  // Write next-state: beat count, not wlast, ends the data phase
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid && aw_ok) w_next = W_DATA;
      W_DATA:  if (wvalid && wcnt == 8'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, burst context and sticky error accumulation into bresp
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      bresp   <= OKAY;
      bid     <= '0;
`ifdef SRAM_RAND_DELAY_EN
      aw_hold <= '0;
`endif
    end else begin
      w_state <= w_next;
      if (awvalid && aw_ok) begin
        waddr    <= awaddr;
        wlen     <= awlen;
        wsize    <= awsize;
        wburst   <= awburst;
        wcnt     <= awlen;
        bid      <= awid;
        werr_slv <= burst_err(awlen, awsize, awburst);
        werr_dec <= 1'b0;
      end
      if (w_hs) begin
        waddr <= next_addr(waddr, wlen, wsize, wburst);
        if (wcnt != 8'd0) begin
          wcnt     <= wcnt - 8'd1;
          werr_dec <= werr_dec | beat_dec;
          werr_slv <= werr_slv | beat_slv;
        end else begin
          bresp <= (werr_dec || beat_dec) ? DECERR :
                   (werr_slv || beat_slv) ? SLVERR : OKAY;
        end
      end
`ifdef SRAM_RAND_DELAY_EN
      if (w_state == W_RESP && bready) aw_hold <= lfsr[1:0];
      else if (w_state == W_IDLE && aw_hold != 2'd0) aw_hold <= aw_hold - 2'd1;
`endif
    end
  end

  // Byte-strobed array write; out-of-range beats are dropped
  always_ff @(posedge clock) begin
    if (!reset && w_hs && in_range(waddr)) begin
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (wstrb[i]) mem[waddr[IDX_WIDTH+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_axi4_burst_sram.sv
// Randomized self-checking bench with a behavioural memory/burst model.
module tb_ysyx_20020207_axi4_burst_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 0, reset = 1;
  logic        awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bvalid, bready = 0;
  logic        arready, arvalid = 0, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
  logic [3:0]  awid = 0, arid = 0, wstrb = 0, bid, rid;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 0, arsize = 0;
  logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;

  int          total = 0, bad = 0;
  logic [31:0] mdl [0:63];
  logic [31:0] wd [0:63];
  logic [3:0]  ws [0:63];
  logic [31:0] last_rdata;
  logic [1:0]  last_bresp;

  ysyx_20020207_axi4_burst_sram dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic inr(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd256);  // bench only touches the first 64 words
  endfunction

  function automatic logic berr(input logic [7:0] len, input logic [2:0] size, input logic [1:0] b);
    return b == 2'b11 || size > 3'd2 ||
           (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Address of beat i from the burst definition (wrap = modulo inside aligned window)
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] b);
    logic [31:0] step, tot, base;
    step = 32'd1 << size;
    tot  = (32'(len) + 1) * step;
    if (b == 2'b00) return a;
    if (b == 2'b10 && !berr(len, size, b)) begin
      base = a - (a % tot);
      return base + ((a - base + 32'(i) * step) % tot);
    end
    return a + 32'(i) * step;
  endfunction

  task automatic axi_wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] b, input logic [3:0] id, input int wl_mode, input string tag);
    logic [1:0] eresp; logic dec, slv, wl; logic [31:0] ba; int n;
    dec = 0; slv = berr(len, size, b);
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, i, len, size, b);
      wl = (wl_mode == 1) ? (i == 0) : (i == int'(len));
      if (wl != (i == int'(len))) slv = 1;
      if (!inr(ba)) begin
        if (ba < BASE || ba >= BASE + 32'h4000) dec = 1;
      end else
        for (int k = 0; k < 4; k++) if (ws[i][k]) mdl[(ba - BASE) >> 2][8*k +: 8] = wd[i][8*k +: 8];
    end
    eresp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    awvalid = 1; awaddr = a; awlen = len; awsize = size; awburst = b; awid = id;
    n = 0; do begin @(negedge clock); n++; end while (!awready && n < 100);
    if (!awready) chk({tag, ":awready"}, awready, 1);
    @(posedge clock); #1; awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i];
      wlast = (wl_mode == 1) ? (i == 0) : (i == int'(len));
      n = 0; do begin @(negedge clock); n++; end while (!wready && n < 100);
      if (!wready) chk({tag, ":wready"}, wready, 1);
      @(posedge clock); #1;
    end
    wvalid = 0; wlast = 0; bready = 1;
    n = 0; do begin @(negedge clock); n++; end while (!bvalid && n < 100);
    chk({tag, ":bvalid"}, bvalid, 1);
    chk({tag, ":bresp"}, bresp, eresp);
    chk({tag, ":bid"}, bid, id);
    last_bresp = bresp;
    @(posedge clock); #1; bready = 0;
  endtask

  // stall_mode: 0 = always ready (throughput checked), 1 = random stalls, 2 = 3-cycle stall on beat 2
  task automatic axi_rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] b, input logic [3:0] id, input int stall_mode, input string tag);
    logic [31:0] ba, ed; logic [1:0] er; int n, stall;
    arvalid = 1; araddr = a; arlen = len; arsize = size; arburst = b; arid = id;
    n = 0; do begin @(negedge clock); n++; end while (!arready && n < 100);
    if (!arready) chk({tag, ":arready"}, arready, 1);
    @(posedge clock); #1; arvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, i, len, size, b);
      ed = inr(ba) ? mdl[(ba - BASE) >> 2] : 32'h0;
      er = (ba < BASE || ba >= BASE + 32'h4000) ? 2'b11 : (berr(len, size, b) ? 2'b10 : 2'b00);
      stall = (stall_mode == 1) ? int'($urandom_range(0, 2)) : (stall_mode == 2 && i == 1) ? 3 : 0;
      rready = 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        chk({tag, ":hold_rvalid"}, rvalid, 1);
        chk({tag, ":hold_rdata"}, rdata, ed);
        @(posedge clock); #1;
      end
      rready = 1; n = 0;
      @(negedge clock);
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      if (stall_mode == 0) chk({tag, ":lat"}, n, 0);
      chk({tag, ":rdata"}, rdata, ed);
      chk({tag, ":rresp"}, rresp, er);
      chk({tag, ":rlast"}, rlast, i == int'(len));
      chk({tag, ":rid"}, rid, id);
      last_rdata = rdata;
      @(posedge clock); #1;
    end
    rready = 0;
    @(negedge clock);
    chk({tag, ":rvalid_end"}, rvalid, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] a; logic [7:0] len; logic [2:0] size; logic [1:0] b; logic [3:0] id; int w;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_awready", awready, 1); chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_ids", {rid, bid}, 0);
    @(posedge clock); #1;

    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_wr(BASE, 8'd63, 3'd2, 2'b01, 4'd1, 0, "preload");

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_wr(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'd2, 0, "single_wr");
    axi_rd(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'd2, 0, "single_rd");
    chk("single_val", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_wr(BASE, 8'd3, 3'd2, 2'b01, 4'd0, 0, "incr_wr");
    axi_rd(BASE, 8'd3, 3'd2, 2'b01, 4'd5, 0, "incr_rd");
    axi_rd(BASE, 8'd3, 3'd2, 2'b01, 4'd5, 2, "incr_stall");
    axi_rd(BASE + 32'h8, 8'd3, 3'd2, 2'b10, 4'd6, 0, "wrap_rd");
    chk("wrap_last", last_rdata, 32'd2);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_wr(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd3, 0, "strb_init");
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_wr(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd3, 0, "strb_wr");
    axi_rd(BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'd3, 0, "strb_rd");
    chk("strb_val", last_rdata, 32'h11BB33DD);

    axi_rd(32'h0, 8'd0, 3'd2, 2'b01, 4'd7, 0, "decerr_rd");
    wd[0] = 32'h5; ws[0] = 4'hF;
    axi_wr(32'h1000, 8'd0, 3'd2, 2'b01, 4'd8, 0, "decerr_wr");
    chk("decerr_wr_val", last_bresp, 2'b11);
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_wr(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'd9, 1, "wlast_err");
    chk("wlast_err_val", last_bresp, 2'b10);
    axi_rd(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'd9, 0, "wlast_rd");

    // reset while beat 2 of a len-7 read is on the bus
    arvalid = 1; araddr = BASE; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'd3;
    @(negedge clock); chk("mr_arready", arready, 1);
    @(posedge clock); #1; arvalid = 0; rready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); chk("mr_beat", rdata, mdl[i]);
      @(posedge clock); #1;
    end
    rready = 0; reset = 1;
    @(negedge clock); chk("mr_beat2_valid", rvalid, 1);
    @(posedge clock); #1; reset = 0;
    @(negedge clock);
    chk("mr_rvalid", rvalid, 0); chk("mr_arready2", arready, 1); chk("mr_rdata", rdata, 0);
    @(posedge clock); #1;
    axi_rd(BASE + 32'h4, 8'd3, 3'd2, 2'b01, 4'd4, 0, "mr_fresh");

    for (int t = 0; t < 40; t++) begin
      b = 2'($urandom_range(0, 2)); size = 3'($urandom_range(0, 2)); id = 4'($urandom);
      w = int'($urandom_range(0, 63));
      if (b == 2'b10) len = 8'((1 << $urandom_range(1, 4)) - 1);
      else if (b == 2'b01) begin len = 8'($urandom_range(0, 7)); w = int'($urandom_range(0, 55)); end
      else len = 8'($urandom_range(0, 3));
      a = BASE + 32'(w) * 4 + (32'($urandom_range(0, 3)) & ~((32'd1 << size) - 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        axi_wr(a, len, size, b, id, 0, "rnd_wr");
      end else
        axi_rd(a, len, size, b, id, 1, "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
